apb_slave_regbank: RTL and testbench
====================================

// Module: apb_slave_regbank
// PURPOSE
//  APB3 completer (slave) holding NUM_REGS 32-bit read/write registers in a window at BASE_ADDR.
//  Answers a single APB master on the shared peripheral bus: setup/access decode, programmable
//  wait states, PSLVERR on out-of-window access. Register contents and per-register write strobes
//  are exported to downstream logic.
// PARAMETERS
//  BASE_ADDR    32'hDEAD_CAF0  byte address of register 0; window = NUM_REGS*4 bytes
//  NUM_REGS     4              number of 32-bit registers (power of 2, >=2)
//  WAIT_CYCLES  1              access-phase cycles with PREADY low before PREADY high (0..15)
//  RESET_VALUE  32'h0          reset value of every register
// PORTS
//  clk         in   1              clock, all logic on posedge
//  reset       in   1              asynchronous, active-high reset
//  psel_i      in   1              APB PSEL
//  penable_i   in   1              APB PENABLE
//  paddr_i     in   32             APB PADDR, byte address; bits [1:0] ignored
//  pwrite_i    in   1              APB PWRITE, 1=write
//  pwdata_i    in   32             APB PWDATA
//  pready_o    out  1              APB PREADY
//  prdata_o    out  32             APB PRDATA, valid only while pready_o=1 and read
//  pslverr_o   out  1              APB PSLVERR, valid only while pready_o=1
//  regs_o      out  NUM_REGS*32    register contents, reg k at [k*32 +: 32]
//  wr_pulse_o  out  NUM_REGS       1-cycle pulse, the cycle after reg k is written
// BEHAVIOUR
//  Reset (async): state=ST_IDLE, cnt=0, all regs=RESET_VALUE. pready_o, pslverr_o and wr_pulse_o are 0.
//   prdata_o=0. Reset mid-transfer discards the transfer; no write commits.
//  Decode: off=paddr_i-BASE_ADDR (32-bit, wraps). hit = off < NUM_REGS*4. idx = off[2 +: log2(NUM_REGS)].
//   Example: 0xDEADCAFE -> off 0xE -> idx 3, hit.
//  FSM (apb_slv_state_t):
//   ST_IDLE: psel_i & ~penable_i (setup) -> latch idx, hit and pwrite; cnt<=WAIT_CYCLES; -> ST_ACCESS.
//   ST_ACCESS: while psel_i&penable_i: cnt!=0 -> cnt<=cnt-1, stay; cnt==0 -> complete, -> ST_IDLE.
//    psel_i low in ST_ACCESS (protocol abort) -> ST_IDLE, no write, no response.
//  pready_o = (state==ST_ACCESS) & psel_i & penable_i & (cnt==0). This is combinational from state/cnt/inputs.
//   PREADY therefore rises exactly WAIT_CYCLES cycles after the first access cycle. With WAIT_CYCLES=0,
//   PREADY is high in the first access cycle, so the transfer takes 2 cycles total.
//  Completion = pready_o=1 cycle:
//   write & hit : reg[idx]<=pwdata_i at the clock edge; wr_pulse_o[idx]=1 the following cycle.
//   read  & hit : prdata_o=reg[idx] (value before any same-edge write).
//   ~hit        : pslverr_o=1, prdata_o=0, no register changes.
//  prdata_o=0 and pslverr_o=0 whenever pready_o=0.
//  Transfer attributes (idx/hit/write) are latched at setup. paddr_i/pwrite_i changes during access are ignored.
//   pwdata_i is sampled at completion.
//  Back-to-back transfers: a new setup is recognised in the cycle after completion (state is ST_IDLE).
//  psel_i&penable_i seen in ST_IDLE (missing setup): ignored, pready_o stays 0.
//  wr_pulse_o is at most one-hot. regs_o updates one cycle after completion.
// STRUCTURE
//  apb_pkg: apb_slv_state_t {ST_IDLE, ST_ACCESS}, APB_AW=32, APB_DW=32 constants.
//  Sub-module apb_slave_regbank_regs: register array + write-enable decode + wr_pulse_o generation.
//  The top holds the FSM, wait counter, address decode and read mux.
// TESTING
//  1 Reset, read 0xDEADCAFE (WAIT_CYCLES=1) -> PREADY high 1 cycle into access, PRDATA=0, PSLVERR=0.
//  2 Write 0x0000_0005 to 0xDEADCAFE, then read it -> regs_o[127:96]=5, wr_pulse_o=4'b1000 for 1 cycle,
//    read returns 5.
//  3 Write 0x1234_5678 to 0xDEADCB00 (out of window) -> PSLVERR=1 with PREADY, regs_o unchanged,
//    wr_pulse_o=0.
//  4 WAIT_CYCLES=3 -> PREADY low for exactly 3 access cycles, high on the 4th. With WAIT_CYCLES=0,
//    PREADY high in the first access cycle.
//  5 Drop PSEL after 1 access cycle of a write (WAIT_CYCLES=3) -> no write, FSM in ST_IDLE, next read OK.
//  6 Assert reset during the access phase of a write of 0xFFFF_FFFF -> all regs=RESET_VALUE,
//    PREADY=0, no wr_pulse_o.

Source files
------------

// File: rtl/apb_slave_regbank_pkg.sv
// Shared types and bus widths for the APB register bank.
package apb_slave_regbank_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_slv_state_t;

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB3 bus bundle between one master and the register-bank completer.
interface apb_slave_regbank_if;
  import apb_slave_regbank_pkg::*;

  logic              psel_i;
  logic              penable_i;
  logic [APB_AW-1:0] paddr_i;
  logic              pwrite_i;
  logic [APB_DW-1:0] pwdata_i;
  logic              pready_o;
  logic [APB_DW-1:0] prdata_o;
  logic              pslverr_o;

  modport master (
    output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
    input  pready_o, prdata_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
    output pready_o, prdata_o, pslverr_o
  );

endinterface

// File: rtl/apb_slave_regbank_regs.sv
// Register storage with indexed write enable and a one-cycle write pulse per register.
module apb_slave_regbank_regs
  import apb_slave_regbank_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 4,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en_i,
  input  logic [$clog2(NUM_REGS)-1:0]   wr_idx_i,
  input  logic [APB_DW-1:0]             wr_data_i,
  output logic [NUM_REGS*APB_DW-1:0]    regs_o,
  output logic [NUM_REGS-1:0]           wr_pulse_o
);

  logic [APB_DW-1:0]   regs_q [NUM_REGS];
  logic [APB_DW-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q;
  logic [NUM_REGS-1:0] wr_pulse_d;

  always_comb begin
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
    end
    wr_pulse_d = '0;
    if (wr_en_i) begin
      regs_d[wr_idx_i]     = wr_data_i;
      wr_pulse_d[wr_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RESET_VALUE;
      end
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_o[k*APB_DW +: APB_DW] = regs_q[k];
  end

  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: rtl/apb_slave_regbank.sv
// APB3 completer exposing NUM_REGS read/write registers at BASE_ADDR with programmable wait states.
module apb_slave_regbank
  import apb_slave_regbank_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hDEAD_CAF0,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  apb_slave_regbank_if.slave         apb,
  output logic [NUM_REGS*APB_DW-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  localparam int unsigned IDX_W     = $clog2(NUM_REGS);
  localparam int unsigned CNT_W     = 4;
  localparam logic [APB_AW-1:0] WIN_BYTES = APB_AW'(NUM_REGS * 4);

  apb_slv_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              hit_q, hit_d;
  logic              write_q, write_d;

  logic [APB_AW-1:0] off;
  logic              done;
  logic [APB_DW-1:0] rd_data;

  // Offset wraps, so addresses below BASE_ADDR land far outside the window.
  assign off = apb.paddr_i - BASE_ADDR;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    write_d = write_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (apb.psel_i && !apb.penable_i) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          idx_d   = off[2 +: IDX_W];
          hit_d   = (off < WIN_BYTES);
          write_d = apb.pwrite_i;
        end
      end
      ST_ACCESS: begin
        if (!apb.psel_i) begin
          state_d = ST_IDLE;
        end else if (apb.penable_i) begin
          if (cnt_q == '0) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      write_q <= write_d;
    end
  end

  // Read mux sees pre-write contents, so a same-edge write never leaks into PRDATA.
  assign rd_data       = regs_o[idx_q*APB_DW +: APB_DW];
  assign apb.pready_o  = done;
  assign apb.pslverr_o = done && !hit_q;
  assign apb.prdata_o  = (done && hit_q && !write_q) ? rd_data : '0;

  apb_slave_regbank_regs #(
    .NUM_REGS    (NUM_REGS),
    .RESET_VALUE (RESET_VALUE)
  ) u_regs (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (done && hit_q && write_q),
    .wr_idx_i   (idx_q),
    .wr_data_i  (apb.pwdata_i),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Randomized scoreboard bench: three banks with 1, 0 and 3 wait states against an address/array model.
module tb_apb_slave_regbank;

  localparam logic [31:0] BASE = 32'hDEAD_CAF0;

  typedef struct packed {
    logic [31:0]  rdata;
    logic         rd;
    logic         err;
    logic [7:0]   lat;
    logic [3:0]   wr;
    logic [127:0] regs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] paddr = '0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  int          dsel = 0;

  logic         pready_w  [3];
  logic [31:0]  prdata_w  [3];
  logic         pslverr_w [3];
  logic [127:0] regs_w    [3];
  logic [3:0]   wr_w      [3];

  exp_t        exp_q [3][$];
  logic [31:0] model [3][4];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  function automatic logic [127:0] pack(input int d);
    logic [127:0] p;
    for (int k = 0; k < 4; k++) p[k*32 +: 32] = model[d][k];
    return p;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    apb_slave_regbank_if bus ();

    assign bus.psel_i    = psel && (dsel == g);
    assign bus.penable_i = penable && (dsel == g);
    assign bus.paddr_i   = paddr;
    assign bus.pwrite_i  = pwrite;
    assign bus.pwdata_i  = pwdata;
    assign pready_w[g]   = bus.pready_o;
    assign prdata_w[g]   = bus.prdata_o;
    assign pslverr_w[g]  = bus.pslverr_o;

    apb_slave_regbank #(
      .BASE_ADDR   (BASE),
      .NUM_REGS    (4),
      .WAIT_CYCLES (WC),
      .RESET_VALUE (32'h0)
    ) dut (
      .clk        (clk),
      .reset      (rst),
      .apb        (bus),
      .regs_o     (regs_w[g]),
      .wr_pulse_o (wr_w[g])
    );

    // Monitor: pops the expected response whenever this bank raises PREADY.
    initial begin : mon
      int   acc;
      bit   pend;
      exp_t cur;
      acc = 0; pend = 0; cur = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          acc = 0; pend = 0;
        end else begin
          if (pend) begin
            chk($sformatf("d%0d wr_pulse_after", g), 128'(wr_w[g]), 128'(cur.wr));
            chk($sformatf("d%0d regs_after", g), regs_w[g], cur.regs);
            pend = 0;
          end else begin
            chk($sformatf("d%0d wr_pulse_idle", g), 128'(wr_w[g]), 128'(0));
          end
          if (bus.psel_i && !bus.penable_i) acc = 0;
          else if (bus.psel_i && bus.penable_i) acc++;
          if (pready_w[g]) begin
            if (exp_q[g].size() == 0) begin
              total++; bad++;
              $display("FAIL d%0d unexpected_pready act=1 exp=0", g);
            end else begin
              cur = exp_q[g].pop_front();
              chk($sformatf("d%0d pslverr", g), 128'(pslverr_w[g]), 128'(cur.err));
              if (cur.rd) chk($sformatf("d%0d prdata", g), 128'(prdata_w[g]), 128'(cur.rdata));
              chk($sformatf("d%0d latency", g), 128'(acc), 128'(cur.lat));
              pend = 1;
            end
          end else begin
            chk($sformatf("d%0d prdata_idle", g), 128'(prdata_w[g]), 128'(0));
            chk($sformatf("d%0d pslverr_idle", g), 128'(pslverr_w[g]), 128'(0));
          end
        end
      end
    end
  end

  // Full transfer starting just after a rising edge; expected response queued at setup.
  task automatic xfer(input int d, input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    logic [31:0] off;
    logic        hit;
    int          idx;
    exp_t        e;
    logic        seen;
    int          k;
    off = addr - BASE;
    hit = (off < 32'd16);
    idx = int'(off[3:2]);
    e = '0;
    e.rd  = !wr;
    e.err = !hit;
    e.lat = 8'(wait_of(d) + 1);
    if (!wr && hit) e.rdata = model[d][idx];
    if (wr && hit) begin
      model[d][idx] = wd;
      e.wr = 4'(1 << idx);
    end
    e.regs = pack(d);
    exp_q[d].push_back(e);
    dsel = d; psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = $urandom;
    @(posedge clk); #1;
    penable = 1'b1; seen = 1'b0; k = 0;
    while (!seen && k < 40) begin
      pwdata = (k == wait_of(d)) ? wd : $urandom;
      paddr  = $urandom;
      if (k > 0) pwrite = 1'($urandom_range(0, 1));
      @(negedge clk);
      seen = pready_w[d];
      @(posedge clk); #1;
      k++;
    end
    chk($sformatf("d%0d pready_seen", d), 128'(seen), 128'(1));
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [31:0] a;
    int          d;
    int          r;
    for (int i = 0; i < 3; i++) for (int k = 0; k < 4; k++) model[i][k] = '0;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d reset_regs", i), regs_w[i], 128'(0));
      chk($sformatf("d%0d reset_wr", i), 128'(wr_w[i]), 128'(0));
      chk($sformatf("d%0d reset_pready", i), 128'(pready_w[i]), 128'(0));
      chk($sformatf("d%0d reset_pslverr", i), 128'(pslverr_w[i]), 128'(0));
    end
    @(posedge clk); #1 rst = 1'b0;
    idle(1);

    // Directed: read after reset, write/read back, out-of-window write.
    xfer(0, 32'hDEAD_CAFE, 1'b0, 32'h0);
    xfer(0, 32'hDEAD_CAFE, 1'b1, 32'h0000_0005);
    xfer(0, 32'hDEAD_CAFE, 1'b0, 32'h0);
    xfer(0, 32'hDEAD_CB00, 1'b1, 32'h1234_5678);
    idle(1);

    // Wait-state extremes.
    xfer(2, 32'hDEAD_CAF4, 1'b1, 32'hA5A5_0001);
    xfer(2, 32'hDEAD_CAF4, 1'b0, 32'h0);
    xfer(1, 32'hDEAD_CAF8, 1'b1, 32'h0BAD_F00D);
    xfer(1, 32'hDEAD_CAF8, 1'b0, 32'h0);

    // Aborted write: PSEL drops after one access cycle.
    dsel = 2; psel = 1'b1; penable = 1'b0; paddr = 32'hDEAD_CAF4; pwrite = 1'b1; pwdata = 32'hDEAD_0000;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    idle(1);
    xfer(2, 32'hDEAD_CAF4, 1'b0, 32'h0);

    // Access phase without a setup phase is ignored.
    dsel = 0; psel = 1'b1; penable = 1'b1; paddr = 32'hDEAD_CAF0; pwrite = 1'b1; pwdata = 32'hFFFF_0000;
    idle(2);
    psel = 1'b0; penable = 1'b0;
    idle(1);
    xfer(0, 32'hDEAD_CAF0, 1'b0, 32'h0);

    // Randomized traffic across all three banks.
    for (int n = 0; n < 150; n++) begin
      d = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r <= 6)      a = BASE + 32'($urandom_range(0, 15));
      else if (r == 7) a = BASE + 32'd16 + 32'($urandom_range(0, 63));
      else if (r == 8) a = BASE - 32'd1 - 32'($urandom_range(0, 15));
      else             a = $urandom;
      xfer(d, a, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    // Reset during the access phase of a write.
    dsel = 2; psel = 1'b1; penable = 1'b0; paddr = 32'hDEAD_CAF0; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d midreset_regs", i), regs_w[i], 128'(0));
      chk($sformatf("d%0d midreset_pready", i), 128'(pready_w[i]), 128'(0));
      chk($sformatf("d%0d midreset_wr", i), 128'(wr_w[i]), 128'(0));
      exp_q[i].delete();
      for (int k = 0; k < 4; k++) model[i][k] = '0;
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    idle(1);
    for (int i = 0; i < 3; i++) chk($sformatf("d%0d post_reset_wr", i), 128'(wr_w[i]), 128'(0));
    xfer(2, 32'hDEAD_CAF0, 1'b0, 32'h0);
    for (int n = 0; n < 20; n++) begin
      xfer($urandom_range(0, 2), BASE + 32'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
    end

    idle(4);
    for (int i = 0; i < 3; i++) chk($sformatf("d%0d queue_drained", i), 128'(exp_q[i].size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
